// File: rtl/mult_share_ctrl.sv
// Two-requester arbiter and strobe sequencer for the shared shift-add multiplier.
// Define MULT_RR_ARB_EN for round-robin arbitration; otherwise req0 has fixed priority.
module mult_share_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic lsb,
  output logic init,
  output logic add,
  output logic SR,
  output logic sel,
  output logic busy,
  output logic ack0,
  output logic ack1
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req;
  logic             req_sel;
  logic             win;

  assign req     = {req1, req0};
  assign req_sel = req[sel];

  // SR is high exactly in CALC, so add follows the live multiplier LSB only then
  assign add = SR & lsb;

`ifdef MULT_RR_ARB_EN
  // ptr names the requester favoured on the next tie; it is written with the
  // complement of the requester just served, so a tie after reset goes to 0.
  logic ptr;
  always_comb win = (req0 && req1) ? ptr : req1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ptr <= 1'b0;
    else if (state == CALC && cnt == CNT_W'(WIDTH-1))
      ptr <= ~sel;
  end
`else
  always_comb win = ~req0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
      init  <= 1'b0;
      SR    <= 1'b0;
      busy  <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel   <= win;
            init  <= 1'b1;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          init  <= 1'b0;
          SR    <= 1'b1;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            SR    <= 1'b0;
            ack0  <= ~sel;
            ack1  <= sel;
            state <= DONE;
          end
        end
        DONE: begin
          // ack holds for the whole handshake; an early drop makes it a single-cycle pulse
          if (!req_sel) begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboarded bench: a behavioural shift-add datapath answers the strobes and
// each ack is checked against the product queued when the request was raised.
module tb_mult_share_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int PW    = 2 * WIDTH;

  typedef struct {
    logic          id;
    logic [PW-1:0] prod;
  } sb_t;

  logic clock = 1'b0;
  logic reset, req0, req1, lsb;
  logic init, add, SR, sel, busy, ack0, ack1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  sb_t sb[$];

  logic [WIDTH-1:0] mcand [2];
  logic [WIDTH-1:0] mplier[2];
  logic [WIDTH-1:0] acc, mq, md;
  logic             ack_prev;

  always #5 clock = ~clock;

  mult_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .lsb(lsb),
    .init(init), .add(add), .SR(SR), .sel(sel), .busy(busy),
    .ack0(ack0), .ack1(ack1)
  );

  function automatic logic [PW-1:0] dp_step(logic [WIDTH-1:0] a, logic [WIDTH-1:0] q,
                                            logic [WIDTH-1:0] m, logic ad);
    logic [WIDTH:0] s;
    s = {1'b0, a} + (ad ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, q[WIDTH-1:1]};
  endfunction

  // datapath model: add then shift in the same cycle
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0; mq <= '0; md <= '0;
    end else if (init) begin
      acc <= '0; mq <= mplier[sel]; md <= mcand[sel];
    end else if (SR) begin
      {acc, mq} <= dp_step(acc, mq, md, add);
    end
  end
  assign lsb = mq[0];

  function automatic logic [PW-1:0] prod_of(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // expected {init,SR,add,sel,busy,ack0,ack1} k negedges after the request was raised
  function automatic logic [6:0] exp_vec(int k, logic [WIDTH-1:0] mp, logic s);
    if (k == 1)                return {3'b100, s, 1'b1, 2'b00};
    if (k >= 2 && k <= WIDTH+1) return {2'b01, mp[k-2], s, 1'b1, 2'b00};
    if (k == WIDTH+2)          return {3'b000, s, 1'b1, ~s, s};
    return {3'b000, s, 3'b000};
  endfunction

  // ack scoreboard and strobe invariants
  always @(negedge clock) begin
    if (!reset) begin
      ack_prev = 1'b0;
    end else begin
      if ((ack0 | ack1) && !ack_prev) begin
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL sb_ack: ack seen (ack1=%b) but no request expected", ack1);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if ({ack1, acc, mq} !== {e.id, e.prod})
            $display("FAIL sb_result: got id=%b prod=%0d, expected id=%b prod=%0d",
                     ack1, {acc, mq}, e.id, e.prod);
          else pass_cnt++;
        end
      end
      ack_prev = ack0 | ack1;
      chk_cnt++;
      if ((init && SR) || ((init || SR || add) && (!busy || ack0 || ack1)) || (ack0 && ack1))
        $display("FAIL strobe_invariant: init=%b SR=%b add=%b busy=%b ack0=%b ack1=%b",
                 init, SR, add, busy, ack0, ack1);
      else pass_cnt++;
    end
  end

  task automatic test_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({init, SR, add, sel, busy, ack0, ack1} !== 7'b0)
      $display("FAIL reset_state: got %b expected 0000000", {init, SR, add, sel, busy, ack0, ack1});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [6:0] e;
    mcand[0] = 4'd13; mplier[0] = 4'b1011;
    sb.push_back('{1'b0, prod_of(4'd13, 4'b1011)});
    req0 = 1'b1;
    for (int k = 1; k <= WIDTH+3; k++) begin
      @(negedge clock);
      e = exp_vec(k, mplier[0], 1'b0);
      chk_cnt++;
      if ({init, SR, add, sel, busy, ack0, ack1} !== e)
        $display("FAIL single k=%0d: got %b expected %b", k, {init, SR, add, sel, busy, ack0, ack1}, e);
      else pass_cnt++;
      if (k == WIDTH+2) req0 = 1'b0;
    end
  endtask

  task automatic test_release();
    logic [6:0] e;
    int n;
    mcand[0] = 4'd5; mplier[0] = 4'b0110;
    sb.push_back('{1'b0, prod_of(4'd5, 4'b0110)});
    req0 = 1'b1;
    for (int k = 1; k <= WIDTH+5; k++) begin
      @(negedge clock);
      if (k <= WIDTH+2)      e = exp_vec(k, mplier[0], 1'b0);
      else if (k <= WIDTH+4) e = 7'b0000110;
      else                   e = 7'b0000000;
      chk_cnt++;
      if ({init, SR, add, sel, busy, ack0, ack1} !== e)
        $display("FAIL release k=%0d: got %b expected %b", k, {init, SR, add, sel, busy, ack0, ack1}, e);
      else pass_cnt++;
      if (k == WIDTH+4) req0 = 1'b0;
    end
    // one IDLE cycle has passed: a new request is granted on the next edge
    mcand[0] = 4'd9; mplier[0] = 4'b0011;
    sb.push_back('{1'b0, prod_of(4'd9, 4'b0011)});
    req0 = 1'b1;
    @(negedge clock);
    chk_cnt++;
    if ({init, sel} !== 2'b10)
      $display("FAIL release_regrant: got init,sel=%b expected 10", {init, sel});
    else pass_cnt++;
    n = 0;
    while (!ack0 && n < 20) begin @(negedge clock); n++; end
    chk_cnt++;
    if (!ack0) $display("FAIL release_ack_timeout: ack0=%b after %0d cycles, expected 1", ack0, n);
    else pass_cnt++;
    req0 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_simultaneous();
    logic g[3];
    int n;
`ifdef MULT_RR_ARB_EN
    g[0] = 1'b0; g[1] = 1'b1; g[2] = 1'b0;
`else
    g[0] = 1'b0; g[1] = 1'b0; g[2] = 1'b1;
`endif
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mcand[0] = 4'd3; mplier[0] = 4'b1001;
    mcand[1] = 4'd7; mplier[1] = 4'b0101;
    for (int r = 0; r < 3; r++)
      sb.push_back('{g[r], prod_of(mcand[g[r]], mplier[g[r]])});
    req0 = 1'b1; req1 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!init && n < 20);
      chk_cnt++;
      if ({init, sel} !== {1'b1, g[r]})
        $display("FAIL simul_grant%0d: got init,sel=%b expected 1%b", r, {init, sel}, g[r]);
      else pass_cnt++;
      n = 0;
      while (!(ack0 | ack1) && n < 20) begin @(negedge clock); n++; end
      chk_cnt++;
      if ({ack1, ack0} !== {g[r], ~g[r]})
        $display("FAIL simul_ack%0d: got ack1,ack0=%b expected %b", r, {ack1, ack0}, {g[r], ~g[r]});
      else pass_cnt++;
      if (g[r]) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clock);
      // only the first served requester comes back for a second round
      if (r == 0) begin
        if (g[r]) req1 = 1'b1; else req0 = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_busy_request();
    logic [6:0] e;
    int n;
    mcand[0] = 4'd11; mplier[0] = 4'b1101;
    mcand[1] = 4'd6;  mplier[1] = 4'b1010;
    sb.push_back('{1'b0, prod_of(4'd11, 4'b1101)});
    sb.push_back('{1'b1, prod_of(4'd6, 4'b1010)});
    req0 = 1'b1;
    for (int k = 1; k <= WIDTH+3; k++) begin
      @(negedge clock);
      e = exp_vec(k, mplier[0], 1'b0);
      chk_cnt++;
      if ({init, SR, add, sel, busy, ack0, ack1} !== e)
        $display("FAIL busy_req k=%0d: got %b expected %b", k, {init, SR, add, sel, busy, ack0, ack1}, e);
      else pass_cnt++;
      if (k == 3) req1 = 1'b1;
      if (k == WIDTH+2) req0 = 1'b0;
    end
    @(negedge clock);
    chk_cnt++;
    if ({init, sel, busy} !== 3'b111)
      $display("FAIL busy_req_grant1: got init,sel,busy=%b expected 111", {init, sel, busy});
    else pass_cnt++;
    n = 0;
    while (!ack1 && n < 20) begin @(negedge clock); n++; end
    chk_cnt++;
    if (!ack1) $display("FAIL busy_req_ack1_timeout: ack1=%b expected 1", ack1);
    else pass_cnt++;
    req1 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    mcand[0] = 4'd15; mplier[0] = 4'b0111;
    sb.push_back('{1'b0, prod_of(4'd15, 4'b0111)});
    req0 = 1'b1;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++;
    if ({init, SR, add, sel, busy, ack0, ack1} !== 7'b0)
      $display("FAIL reset_mid: got %b expected 0000000", {init, SR, add, sel, busy, ack0, ack1});
    else pass_cnt++;
    sb.delete();
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    mcand[0] = 4'd10; mplier[0] = 4'b1110;
    sb.push_back('{1'b0, prod_of(4'd10, 4'b1110)});
    req0 = 1'b1;
    for (int k = 1; k <= WIDTH+3; k++) begin
      @(negedge clock);
      e = exp_vec(k, mplier[0], 1'b0);
      chk_cnt++;
      if ({init, SR, add, sel, busy, ack0, ack1} !== e)
        $display("FAIL reset_mid_redo k=%0d: got %b expected %b", k, {init, SR, add, sel, busy, ack0, ack1}, e);
      else pass_cnt++;
      if (k == WIDTH+2) req0 = 1'b0;
    end
  endtask

  task automatic test_early_drop();
    logic [6:0] e;
    mcand[1] = 4'd15; mplier[1] = 4'b1111;
    sb.push_back('{1'b1, prod_of(4'd15, 4'b1111)});
    req1 = 1'b1;
    for (int k = 1; k <= WIDTH+4; k++) begin
      @(negedge clock);
      e = exp_vec(k, mplier[1], 1'b1);
      chk_cnt++;
      if ({init, SR, add, sel, busy, ack0, ack1} !== e)
        $display("FAIL early_drop k=%0d: got %b expected %b", k, {init, SR, add, sel, busy, ack0, ack1}, e);
      else pass_cnt++;
      if (k == 3) req1 = 1'b0;
    end
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    mcand[0] = '0; mcand[1] = '0; mplier[0] = '0; mplier[1] = '0;
    test_reset();
    test_single();
    test_release();
    test_simultaneous();
    test_busy_request();
    test_reset_mid();
    test_early_drop();
    repeat (2) @(negedge clock);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
